// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package timer_pkg;

  localparam int TIME_W  = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  function automatic logic [TIME_W-1:0] clamp_time(
    input logic [TIME_W-1:0] v,
    input logic [TIME_W-1:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// One-second prescaler: one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer with completion pulse and alarm level.
// Define COUNTDOWN_ALARM_BLINK_EN to make alarm blink once per tick period.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] load_min,
  input  logic [TIME_W-1:0] load_sec,
  input  logic              start,
  input  logic              pause,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              running,
  output logic              done,
  output logic              alarm
);

  localparam logic [TIME_W-1:0] SMAX = TIME_W'(SEC_MAX);
  localparam logic [TIME_W-1:0] MMAX = TIME_W'(MIN_MAX);

  state_t            state, state_n;
  logic [TIME_W-1:0] min_n, sec_n;
  logic              done_n, alarm_n;
  logic              clr, en, tick, is_zero;

  assign is_zero = (min == '0) && (sec == '0);
  assign running = (state == RUN);

`ifdef COUNTDOWN_ALARM_BLINK_EN
  assign en = (state == RUN) || (state == EXPIRED);
`else
  assign en = (state == RUN);
`endif

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      min   <= '0;
      sec   <= '0;
      done  <= 1'b0;
      alarm <= 1'b0;
    end else begin
      state <= state_n;
      min   <= min_n;
      sec   <= sec_n;
      done  <= done_n;
      alarm <= alarm_n;
    end
  end

  always_comb begin
    state_n = state;
    min_n   = min;
    sec_n   = sec;
    done_n  = 1'b0;
    alarm_n = alarm;
    clr     = 1'b0;
    if (load) begin
      min_n   = clamp_time(load_min, MMAX);
      sec_n   = clamp_time(load_sec, SMAX);
      state_n = IDLE;
      alarm_n = 1'b0;
      clr     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !is_zero) begin
            state_n = RUN;
            clr     = 1'b1;
          end
        end
        PAUSE: begin
          if (start && !is_zero) state_n = RUN;
        end
        RUN: begin
          if (tick) begin
            if (sec != '0) begin
              sec_n = sec - 1'b1;
            end else begin
              sec_n = SMAX;
              min_n = min - 1'b1;
            end
          end
          // expiry outranks a coincident pause
          if (tick && min == '0 && sec == TIME_W'(1)) begin
            state_n = EXPIRED;
            done_n  = 1'b1;
            alarm_n = 1'b1;
          end else if (pause) begin
            state_n = PAUSE;
          end
        end
        EXPIRED: begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
          if (tick) alarm_n = !alarm;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst, load, start, pause;
  logic [5:0] load_min, load_sec;
  logic [5:0] min, sec;
  logic       running, done, alarm;

  int errors = 0;
  int checks = 0;

  countdown_timer #(
    .TICK_DIV(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_min(load_min),
    .load_sec(load_sec),
    .start   (start),
    .pause   (pause),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    load_min = m;
    load_sec = s;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] exp_v;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exp_v = {6'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({min, sec, running, done, alarm} !== exp_v) begin
      errors++;
      $display("FAIL reset: got %0d:%0d r%b d%b a%b, want 00:00 r0 d0 a0",
               min, sec, running, done, alarm);
    end
  endtask

  task automatic test_countdown_3();
    do_load(6'd0, 6'd3);
    do_start();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL cd3_running: got %b want 1", running);
    end
    repeat (3) step();
    checks++;
    if ({min, sec} !== {6'd0, 6'd3}) begin
      errors++;
      $display("FAIL cd3_t3: got %0d:%0d want 0:3", min, sec);
    end
    step();
    checks++;
    if ({min, sec} !== {6'd0, 6'd2}) begin
      errors++;
      $display("FAIL cd3_t4: got %0d:%0d want 0:2", min, sec);
    end
    repeat (4) step();
    checks++;
    if ({min, sec} !== {6'd0, 6'd1}) begin
      errors++;
      $display("FAIL cd3_t8: got %0d:%0d want 0:1", min, sec);
    end
    repeat (3) step();
    checks++;
    if ({sec, done, alarm} !== {6'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cd3_t11: got sec=%0d d%b a%b want 1 d0 a0",
               sec, done, alarm);
    end
    step();
    checks++;
    if ({min, sec, running, done, alarm} !==
        {6'd0, 6'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL cd3_t12: got %0d:%0d r%b d%b a%b want 0:0 r0 d1 a1",
               min, sec, running, done, alarm);
    end
    step();
    checks++;
    if ({min, sec, done, alarm} !== {6'd0, 6'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL cd3_t13: got %0d:%0d d%b a%b want 0:0 d0 a1",
               min, sec, done, alarm);
    end
  endtask

  task automatic test_minute_rollover();
    do_load(6'd1, 6'd0);
    do_start();
    repeat (4) step();
    checks++;
    if ({min, sec} !== {6'd0, 6'd59}) begin
      errors++;
      $display("FAIL roll_t4: got %0d:%0d want 0:59", min, sec);
    end
    repeat (235) step();
    checks++;
    if ({min, sec, done} !== {6'd0, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL roll_t239: got %0d:%0d d%b want 0:1 d0", min, sec, done);
    end
    step();
    checks++;
    if ({min, sec, done, alarm} !== {6'd0, 6'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL roll_t240: got %0d:%0d d%b a%b want 0:0 d1 a1",
               min, sec, done, alarm);
    end
  endtask

  task automatic test_pause_resume();
    do_load(6'd0, 6'd5);
    do_start();
    repeat (5) step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if ({sec, running} !== {6'd4, 1'b0}) begin
      errors++;
      $display("FAIL pause_enter: got sec=%0d r%b want 4 r0", sec, running);
    end
    repeat (20) step();
    checks++;
    if ({min, sec, running} !== {6'd0, 6'd4, 1'b0}) begin
      errors++;
      $display("FAIL pause_hold: got %0d:%0d r%b want 0:4 r0",
               min, sec, running);
    end
    do_start();
    step();
    checks++;
    if ({sec, running} !== {6'd4, 1'b1}) begin
      errors++;
      $display("FAIL resume_t1: got sec=%0d r%b want 4 r1", sec, running);
    end
    step();
    checks++;
    if (sec !== 6'd3) begin
      errors++;
      $display("FAIL resume_t2: got sec=%0d want 3", sec);
    end
  endtask

  task automatic test_load_clamp();
    load_min = 6'd62;
    load_sec = 6'd63;
    load = 1'b1;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    checks++;
    if ({min, sec, running, alarm} !== {6'd59, 6'd59, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clamp: got %0d:%0d r%b a%b want 59:59 r0 a0",
               min, sec, running, alarm);
    end
    repeat (6) step();
    checks++;
    if ({min, sec, running} !== {6'd59, 6'd59, 1'b0}) begin
      errors++;
      $display("FAIL clamp_idle: got %0d:%0d r%b want 59:59 r0",
               min, sec, running);
    end
  endtask

  task automatic test_zero_and_expired();
    do_load(6'd0, 6'd0);
    do_start();
    step();
    checks++;
    if ({min, sec, running, done, alarm} !==
        {6'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_start: got %0d:%0d r%b d%b a%b want 0:0 r0 d0 a0",
               min, sec, running, done, alarm);
    end
    do_load(6'd0, 6'd1);
    do_start();
    repeat (4) step();
    checks++;
    if ({done, alarm} !== 2'b11) begin
      errors++;
      $display("FAIL exp_enter: got d%b a%b want d1 a1", done, alarm);
    end
    do_start();
    checks++;
    if ({min, sec, running, done, alarm} !==
        {6'd0, 6'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL exp_start: got %0d:%0d r%b d%b a%b want 0:0 r0 d0 a1",
               min, sec, running, done, alarm);
    end
    do_load(6'd0, 6'd10);
    checks++;
    if ({min, sec, running, alarm} !== {6'd0, 6'd10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exp_load: got %0d:%0d r%b a%b want 0:10 r0 a0",
               min, sec, running, alarm);
    end
  endtask

  task automatic test_rst_mid();
    do_load(6'd0, 6'd10);
    do_start();
    repeat (12) step();
    checks++;
    if ({sec, running} !== {6'd7, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre: got sec=%0d r%b want 7 r1", sec, running);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({min, sec, running, done, alarm} !==
        {6'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: got %0d:%0d r%b d%b a%b want 0:0 r0 d0 a0",
               min, sec, running, done, alarm);
    end
  endtask

  task automatic test_alarm_level();
    logic exp_a;
    do_load(6'd0, 6'd1);
    do_start();
    repeat (7) step();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_t7: got %b want 1", alarm);
    end
    step();
`ifdef COUNTDOWN_ALARM_BLINK_EN
    exp_a = 1'b0;
`else
    exp_a = 1'b1;
`endif
    checks++;
    if (alarm !== exp_a) begin
      errors++;
      $display("FAIL alarm_t8: got %b want %b", alarm, exp_a);
    end
    repeat (4) step();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_t12: got %b want 1", alarm);
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    load_min = '0;
    load_sec = '0;
    test_reset();
    test_countdown_3();
    test_minute_rollover();
    test_pause_resume();
    test_load_clamp();
    test_zero_and_expired();
    test_rst_mid();
    test_alarm_level();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
